// File: rtl/isa_loader_if.sv
// isa_loader bus bundle: DRAM read request/data channel and CCU ISA stream.
// master = loader side, slave = DRAM/CCU side.
interface isa_loader_if #(
    parameter int PORT_WIDTH      = 128,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int BURST_WIDTH     = 4
) ();
    logic                       LDRDRM_RdReqVld;
    logic                       DRMLDR_RdReqRdy;
    logic [DRAM_ADDR_WIDTH-1:0] LDRDRM_RdAddr;
    logic [BURST_WIDTH:0]       LDRDRM_RdLen;
    logic [PORT_WIDTH-1:0]      DRMLDR_RdDat;
    logic                       DRMLDR_RdDatVld;
    logic                       LDRDRM_RdDatRdy;
    logic [PORT_WIDTH-1:0]      ITFCCU_ISARdDat;
    logic                       ITFCCU_ISARdDatVld;
    logic                       ITFCCU_ISARdDatLast;
    logic                       CCUITF_ISARdDatRdy;

    modport master (
        output LDRDRM_RdReqVld, LDRDRM_RdAddr, LDRDRM_RdLen,
        output LDRDRM_RdDatRdy,
        output ITFCCU_ISARdDat, ITFCCU_ISARdDatVld, ITFCCU_ISARdDatLast,
        input  DRMLDR_RdReqRdy, DRMLDR_RdDat, DRMLDR_RdDatVld,
        input  CCUITF_ISARdDatRdy
    );

    modport slave (
        input  LDRDRM_RdReqVld, LDRDRM_RdAddr, LDRDRM_RdLen,
        input  LDRDRM_RdDatRdy,
        input  ITFCCU_ISARdDat, ITFCCU_ISARdDatVld, ITFCCU_ISARdDatLast,
        output DRMLDR_RdReqRdy, DRMLDR_RdDat, DRMLDR_RdDatVld,
        output CCUITF_ISARdDatRdy
    );
endinterface

// File: rtl/isa_loader.sv
// isa_loader: fetches the ISA program from DRAM in credit-limited bursts,
// buffers it in a FWFT FIFO and streams it to the CCU.
// Ports: clk, rst_n, TOP_Start/TOP_IsaBaseAddr/TOP_IsaNumWord (start),
// LDR_Busy/LDR_Done (status), bus (DRAM read + CCU ISA stream).
module isa_loader #(
    parameter int PORT_WIDTH      = 128,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int NUMWORD_WIDTH   = 16,
    parameter int BURST_WIDTH     = 4,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       TOP_Start,
    input  logic [DRAM_ADDR_WIDTH-1:0] TOP_IsaBaseAddr,
    input  logic [NUMWORD_WIDTH-1:0]   TOP_IsaNumWord,
    output logic                       LDR_Busy,
    output logic                       LDR_Done,
    isa_loader_if.master               bus
);
    localparam int MAX_BURST = 1 << BURST_WIDTH;
    localparam int DEPTH     = 1 << FIFO_ADDR_WIDTH;
    localparam int LW        = BURST_WIDTH + 1;
    localparam int CW        = FIFO_ADDR_WIDTH + 1;
    localparam int AW        = DRAM_ADDR_WIDTH;
    localparam int NW        = NUMWORD_WIDTH;
    localparam int BPW       = PORT_WIDTH / 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state;
    logic [AW-1:0]         addr_cnt;
    logic [NW-1:0]         num_word;
    logic [NW-1:0]         req_remain;
    logic [NW-1:0]         sent_cnt;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         wptr;
    logic [CW-1:0]         rptr;
    logic [CW-1:0]         fifo_cnt;
    logic [PORT_WIDTH-1:0] mem [DEPTH];
    logic                  done;

    logic [LW-1:0] len;
    logic          credit_ok;
    logic          req_vld;
    logic          req_hs;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          last;
    logic          dat_rdy;

    assign fifo_cnt = wptr - rptr;
    assign full     = (fifo_cnt == CW'(DEPTH));
    assign empty    = (fifo_cnt == '0);

    assign len = (32'(req_remain) >= 32'(MAX_BURST)) ?
                 LW'(MAX_BURST) : LW'(req_remain);

    // Free slots not yet promised to in-flight beats must cover the burst.
    assign credit_ok = (32'(DEPTH) - 32'(fifo_cnt) - 32'(outstanding))
                       >= 32'(len);

    // Credit only grows while a request waits, so the request stays stable.
    assign req_vld = (state == REQ) && (req_remain != '0) && credit_ok;
    assign req_hs  = req_vld && bus.DRMLDR_RdReqRdy;
    assign dat_rdy = (state != IDLE) && !full;
    assign push    = bus.DRMLDR_RdDatVld && dat_rdy;
    assign pop     = !empty && bus.CCUITF_ISARdDatRdy;
    assign last    = !empty && (sent_cnt == num_word - NW'(1));

    assign bus.LDRDRM_RdReqVld     = req_vld;
    assign bus.LDRDRM_RdAddr       = addr_cnt;
    assign bus.LDRDRM_RdLen        = len;
    assign bus.LDRDRM_RdDatRdy     = dat_rdy;
    assign bus.ITFCCU_ISARdDatVld  = !empty;
    assign bus.ITFCCU_ISARdDat     = empty ? '0 :
                                     mem[rptr[FIFO_ADDR_WIDTH-1:0]];
    assign bus.ITFCCU_ISARdDatLast = last;

    assign LDR_Busy = (state != IDLE);
    assign LDR_Done = done;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[FIFO_ADDR_WIDTH-1:0]] <= bus.DRMLDR_RdDat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_cnt    <= '0;
            num_word    <= '0;
            req_remain  <= '0;
            sent_cnt    <= '0;
            outstanding <= '0;
            wptr        <= '0;
            rptr        <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) wptr <= wptr + CW'(1);
            if (pop)  rptr <= rptr + CW'(1);
            unique case (1'b1)
                (state == IDLE): begin
                    if (TOP_Start) begin
                        addr_cnt    <= TOP_IsaBaseAddr;
                        num_word    <= TOP_IsaNumWord;
                        req_remain  <= TOP_IsaNumWord;
                        sent_cnt    <= '0;
                        outstanding <= '0;
                        if (TOP_IsaNumWord == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                (state != IDLE): begin
                    if (req_hs) begin
                        addr_cnt   <= addr_cnt + AW'(32'(len) * BPW);
                        req_remain <= req_remain - NW'(len);
                        if (req_remain == NW'(len)) state <= DRAIN;
                    end
                    outstanding <= outstanding
                                 + (req_hs ? CW'(len) : CW'(0))
                                 - (push ? CW'(1) : CW'(0));
                    if (pop) begin
                        sent_cnt <= sent_cnt + NW'(1);
                        if (last) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_isa_loader.sv
// Directed self-checking bench for isa_loader with a zero-latency
// DRAM responder and stream/credit/hold monitors.
module tb_isa_loader;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start;
    logic [31:0]  base;
    logic [15:0]  nw;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    isa_loader_if bus ();

    isa_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .TOP_Start       (start),
        .TOP_IsaBaseAddr (base),
        .TOP_IsaNumWord  (nw),
        .LDR_Busy        (busy),
        .LDR_Done        (done),
        .bus             (bus)
    );

    int checks = 0;
    int errors = 0;
    int credit_err = 0;
    int rdy_err = 0;
    int head_err = 0;
    int hold_err = 0;
    int outst_tb = 0;
    int fifo_tb = 0;

    logic [31:0]  beat_q[$];
    logic [31:0]  req_addr_log[$];
    int           req_len_log[$];
    logic [127:0] out_dat_log[$];
    logic         out_last_log[$];

    logic         p_req_stall;
    logic [31:0]  p_addr;
    logic [4:0]   p_len;
    logic         p_head_stall;
    logic [127:0] p_head;

    function automatic logic [127:0] word(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_0F0F, a + 32'h1111_1111};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // DRAM responder and protocol monitor.
    initial begin
        bus.DRMLDR_RdDatVld = 1'b0;
        bus.DRMLDR_RdDat = '0;
        p_req_stall = 1'b0;
        p_head_stall = 1'b0;
        p_addr = '0;
        p_len = '0;
        p_head = '0;
        forever begin
            @(posedge clk);
            if (p_req_stall && (!bus.LDRDRM_RdReqVld ||
                bus.LDRDRM_RdAddr !== p_addr ||
                bus.LDRDRM_RdLen !== p_len)) hold_err++;
            if (p_head_stall && (!bus.ITFCCU_ISARdDatVld ||
                bus.ITFCCU_ISARdDat !== p_head)) head_err++;
            if (bus.DRMLDR_RdDatVld && !bus.LDRDRM_RdDatRdy && busy)
                rdy_err++;
            if (bus.DRMLDR_RdDatVld && bus.LDRDRM_RdDatRdy) begin
                if (beat_q.size() > 0) void'(beat_q.pop_front());
                outst_tb--;
                fifo_tb++;
            end
            if (bus.LDRDRM_RdReqVld && bus.DRMLDR_RdReqRdy) begin
                req_addr_log.push_back(bus.LDRDRM_RdAddr);
                req_len_log.push_back(int'(bus.LDRDRM_RdLen));
                for (int i = 0; i < int'(bus.LDRDRM_RdLen); i++)
                    beat_q.push_back(bus.LDRDRM_RdAddr + 32'(i * 16));
                outst_tb += int'(bus.LDRDRM_RdLen);
            end
            if (bus.ITFCCU_ISARdDatVld && bus.CCUITF_ISARdDatRdy) begin
                out_dat_log.push_back(bus.ITFCCU_ISARdDat);
                out_last_log.push_back(bus.ITFCCU_ISARdDatLast);
                fifo_tb--;
            end
            if (outst_tb + fifo_tb > 16) credit_err++;
            p_req_stall = bus.LDRDRM_RdReqVld && !bus.DRMLDR_RdReqRdy;
            p_addr = bus.LDRDRM_RdAddr;
            p_len = bus.LDRDRM_RdLen;
            p_head_stall = bus.ITFCCU_ISARdDatVld &&
                           !bus.CCUITF_ISARdDatRdy;
            p_head = bus.ITFCCU_ISARdDat;
            #1;
            if (!rst_n) begin
                beat_q.delete();
                outst_tb = 0;
                fifo_tb = 0;
                p_req_stall = 1'b0;
                p_head_stall = 1'b0;
            end
            bus.DRMLDR_RdDatVld = (beat_q.size() > 0);
            bus.DRMLDR_RdDat = (beat_q.size() > 0) ? word(beat_q[0]) : '0;
        end
    end

    task automatic clear_logs();
        req_addr_log.delete();
        req_len_log.delete();
        out_dat_log.delete();
        out_last_log.delete();
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        base = b;
        nw = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max,
                             output int n);
        n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, 1'b1);
    endtask

    task automatic check_stream(input string tag, input logic [31:0] b,
                                input int n);
        int bad_d;
        int bad_l;
        bad_d = 0;
        bad_l = 0;
        chk({tag, "_cnt"}, out_dat_log.size(), n);
        for (int k = 0; k < out_dat_log.size(); k++) begin
            if (out_dat_log[k] !== word(b + 32'(k * 16))) bad_d++;
            if (out_last_log[k] !== (k == n - 1)) bad_l++;
        end
        chk({tag, "_data"}, bad_d, 0);
        chk({tag, "_last"}, bad_l, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_reqvld"}, bus.LDRDRM_RdReqVld, 1'b0);
        chk({tag, "_addr"}, bus.LDRDRM_RdAddr, 32'h0);
        chk({tag, "_len"}, bus.LDRDRM_RdLen, 5'd0);
        chk({tag, "_datrdy"}, bus.LDRDRM_RdDatRdy, 1'b0);
        chk({tag, "_isavld"}, bus.ITFCCU_ISARdDatVld, 1'b0);
        chk({tag, "_isadat"}, bus.ITFCCU_ISARdDat, 128'h0);
        chk({tag, "_last"}, bus.ITFCCU_ISARdDatLast, 1'b0);
    endtask

    initial begin
        int n;
        int vcnt;
        start = 1'b0;
        base = '0;
        nw = '0;
        bus.DRMLDR_RdReqRdy = 1'b0;
        bus.CCUITF_ISARdDatRdy = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        bus.DRMLDR_RdReqRdy = 1'b1;
        bus.CCUITF_ISARdDatRdy = 1'b1;
        @(negedge clk);

        // Basic run.
        clear_logs();
        do_start(32'h1000, 16'd3);
        chk("t1_busy_c1", busy, 1'b1);
        chk("t1_reqvld_c1", bus.LDRDRM_RdReqVld, 1'b1);
        chk("t1_addr", bus.LDRDRM_RdAddr, 32'h1000);
        chk("t1_len", bus.LDRDRM_RdLen, 5'd3);
        @(negedge clk);
        chk("t1_isavld_c2", bus.ITFCCU_ISARdDatVld, 1'b0);
        @(negedge clk);
        chk("t1_isavld_c3", bus.ITFCCU_ISARdDatVld, 1'b1);
        chk("t1_head", bus.ITFCCU_ISARdDat, word(32'h1000));
        chk("t1_last_w1", bus.ITFCCU_ISARdDatLast, 1'b0);
        wait_done("t1_done", 50, n);
        chk("t1_done_cyc", n, 3);
        chk("t1_busy_end", busy, 1'b0);
        @(negedge clk);
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_nreq", req_addr_log.size(), 1);
        check_stream("t1", 32'h1000, 3);

        // Zero length.
        clear_logs();
        do_start(32'h7000, 16'd0);
        chk("t0_done_c1", done, 1'b1);
        chk("t0_busy_c1", busy, 1'b0);
        chk("t0_reqvld", bus.LDRDRM_RdReqVld, 1'b0);
        @(negedge clk);
        chk("t0_done_c2", done, 1'b0);
        chk("t0_busy_c2", busy, 1'b0);
        chk("t0_nreq", req_addr_log.size(), 0);

        // Multi-burst with address wrap.
        clear_logs();
        do_start(32'hFFFF_FFE0, 16'd20);
        wait_done("t2_done", 200, n);
        chk("t2_nreq", req_addr_log.size(), 2);
        if (req_addr_log.size() == 2) begin
            chk("t2_addr0", req_addr_log[0], 32'hFFFF_FFE0);
            chk("t2_len0", req_len_log[0], 16);
            chk("t2_addr1", req_addr_log[1], 32'h0000_00E0);
            chk("t2_len1", req_len_log[1], 4);
        end
        check_stream("t2", 32'hFFFF_FFE0, 20);

        // Backpressure.
        clear_logs();
        bus.CCUITF_ISARdDatRdy = 1'b0;
        do_start(32'h2000, 16'd40);
        repeat (100) @(negedge clk);
        chk("t3_isavld", bus.ITFCCU_ISARdDatVld, 1'b1);
        chk("t3_head", bus.ITFCCU_ISARdDat, word(32'h2000));
        chk("t3_nout", out_dat_log.size(), 0);
        chk("t3_nreq_stall", req_addr_log.size(), 1);
        bus.CCUITF_ISARdDatRdy = 1'b1;
        wait_done("t3_done", 300, n);
        check_stream("t3", 32'h2000, 40);
        chk("t3_nreq", req_len_log.size(), 3);
        if (req_len_log.size() == 3)
            chk("t3_len2", req_len_log[2], 8);
        chk("t3_credit", credit_err, 0);
        chk("t3_datrdy", rdy_err, 0);
        chk("t3_headhold", head_err, 0);

        // Request stall with ignored start.
        clear_logs();
        bus.DRMLDR_RdReqRdy = 1'b0;
        do_start(32'h3000, 16'd5);
        vcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.LDRDRM_RdReqVld && bus.LDRDRM_RdAddr == 32'h3000 &&
                bus.LDRDRM_RdLen == 5'd5) vcnt++;
            start = (i == 1);
            base = 32'h9000;
            nw = 16'd9;
            @(negedge clk);
        end
        start = 1'b0;
        bus.DRMLDR_RdReqRdy = 1'b1;
        wait_done("t4_done", 50, n);
        chk("t4_vld_held", vcnt, 5);
        chk("t4_hold", hold_err, 0);
        check_stream("t4", 32'h3000, 5);
        repeat (3) @(negedge clk);
        chk("t4_busy_after", busy, 1'b0);
        chk("t4_nreq", req_addr_log.size(), 1);
        if (req_addr_log.size() == 1)
            chk("t4_addr", req_addr_log[0], 32'h3000);

        // Reset mid-run.
        clear_logs();
        do_start(32'h4000, 16'd20);
        n = 0;
        while (out_dat_log.size() < 7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach7", out_dat_log.size(), 7);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
        do_start(32'h5000, 16'd2);
        wait_done("t5_done", 50, n);
        check_stream("t5", 32'h5000, 2);
        chk("t5_nreq", req_addr_log.size(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
